// File: rtl/bin_to_bcd_fmt.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bin_to_bcd_fmt                                                             |
// | Sequential signed binary to 7-segment digit-code converter (double dabble) |
// | Option macro: BCD_ZERO_BLANK_EN (leading-zero blanking, adjacent minus)    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module bin_to_bcd_fmt #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      value,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   digits
);

    localparam int                 C_BCD_W    = 4 * DIGITS;
    localparam int                 C_CNT_W    = $clog2(WIDTH + 1);
    localparam logic [C_CNT_W-1:0] C_CNT_LOAD = C_CNT_W'(WIDTH);
    localparam logic [C_CNT_W-1:0] C_CNT_ONE  = C_CNT_W'(1);
    localparam logic [3:0]         C_MINUS    = 4'hA;
    localparam logic [3:0]         C_BLANK    = 4'hB;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_FORMAT = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic                 sign_q, sign_d;
    logic [WIDTH-1:0]     mag_q, mag_d;
    logic [C_BCD_W-1:0]   bcd_q, bcd_d;
    logic [C_CNT_W-1:0]   cnt_q, cnt_d;
    logic [C_BCD_W-1:0]   digits_q, digits_d;
    logic                 done_q, done_d;

    logic [C_BCD_W-1:0]   w_bcd_adj;
    logic [C_BCD_W-1:0]   w_fmt;

    // Add-3 correction on every nibble before the shift.
    for (genvar k = 0; k < DIGITS; k++) begin : g_add3
        assign w_bcd_adj[4*k +: 4] = (bcd_q[4*k +: 4] >= 4'd5) ?
                                     (bcd_q[4*k +: 4] + 4'd3) : bcd_q[4*k +: 4];
    end

`ifdef BCD_ZERO_BLANK_EN
    int w_msd;

    always_comb begin
        w_msd = 0;
        for (int k = 1; k < DIGITS; k++) begin
            if (bcd_q[4*k +: 4] != 4'd0) begin
                w_msd = k;
            end
        end
        w_fmt = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (k <= w_msd) begin
                w_fmt[4*k +: 4] = bcd_q[4*k +: 4];
            end else if (sign_q && (k == w_msd + 1)) begin
                w_fmt[4*k +: 4] = C_MINUS;
            end else begin
                w_fmt[4*k +: 4] = C_BLANK;
            end
        end
    end
`else
    // Fixed-width display: the top position is reserved for the sign.
    always_comb begin
        w_fmt = {(sign_q ? C_MINUS : C_BLANK), bcd_q[C_BCD_W-5:0]};
    end
`endif

    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        mag_d    = mag_q;
        bcd_d    = bcd_q;
        cnt_d    = cnt_q;
        digits_d = digits_q;
        done_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    sign_d  = value[WIDTH-1];
                    // Most negative input wraps to 2^(WIDTH-1), which is the correct unsigned magnitude.
                    mag_d   = value[WIDTH-1] ? (-value) : value;
                    bcd_d   = '0;
                    cnt_d   = C_CNT_LOAD;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                {bcd_d, mag_d} = {w_bcd_adj[C_BCD_W-2:0], mag_q, 1'b0};
                cnt_d          = cnt_q - C_CNT_ONE;
                if (cnt_q == C_CNT_ONE) begin
                    state_d = S_FORMAT;
                end
            end
            S_FORMAT: begin
                digits_d = w_fmt;
                done_d   = 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            sign_q   <= 1'b0;
            mag_q    <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            digits_q <= {DIGITS{C_BLANK}};
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            mag_q    <= mag_d;
            bcd_q    <= bcd_d;
            cnt_q    <= cnt_d;
            digits_q <= digits_d;
            done_q   <= done_d;
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = done_q;
    assign digits = digits_q;

endmodule
`default_nettype wire

// File: tb/tb_bin_to_bcd_fmt.sv
`default_nettype none
// Directed self-checking bench for bin_to_bcd_fmt (default WIDTH=16, DIGITS=8).
// Expected codes follow BCD_ZERO_BLANK_EN when defined, fixed-width format otherwise.
module tb_bin_to_bcd_fmt;

    localparam int WIDTH  = 16;
    localparam int DIGITS = 8;

`ifdef BCD_ZERO_BLANK_EN
    localparam logic [31:0] E_1234 = 32'hBBBB1234;
    localparam logic [31:0] E_0    = 32'hBBBBBBB0;
    localparam logic [31:0] E_M5   = 32'hBBBBBBA5;
    localparam logic [31:0] E_MIN  = 32'hBBA32768;
    localparam logic [31:0] E_MAX  = 32'hBBB32767;
    localparam logic [31:0] E_7    = 32'hBBBBBBB7;
`else
    localparam logic [31:0] E_1234 = 32'hB0001234;
    localparam logic [31:0] E_0    = 32'hB0000000;
    localparam logic [31:0] E_M5   = 32'hA0000005;
    localparam logic [31:0] E_MIN  = 32'hA0032768;
    localparam logic [31:0] E_MAX  = 32'hB0032767;
    localparam logic [31:0] E_7    = 32'hB0000007;
`endif
    localparam logic [31:0] E_RST  = 32'hBBBBBBBB;

    logic              clock = 1'b0;
    logic              reset;
    logic              start;
    logic [WIDTH-1:0]  value;
    logic              busy;
    logic              done;
    logic [4*DIGITS-1:0] digits;

    int checks   = 0;
    int failures = 0;

    logic [15:0] vec_val [5] = '{16'd1234, 16'd0, 16'hFFFB, 16'h8000, 16'h7FFF};
    logic [31:0] vec_exp [5];
    string       vec_nam [5] = '{"v1234", "v0", "vm5", "vmin", "vmax"};

    always #5 clock = ~clock;

    bin_to_bcd_fmt #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .value  (value),
        .busy   (busy),
        .done   (done),
        .digits (digits)
    );

    task automatic test_reset();
        int done_seen;
        reset = 1'b1;
        start = 1'b0;
        value = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        done_seen = 0;
        repeat (5) begin
            @(negedge clock);
            if (done) done_seen++;
        end
        checks++;
        if (digits !== E_RST) begin
            failures++;
            $display("FAIL reset_digits: got %h expected %h", digits, E_RST);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy: got %b expected 0", busy);
        end
        checks++;
        if (done_seen != 0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_done: got %0d pulses expected 0", done_seen);
        end
    endtask

    task automatic test_values();
        int lat;
        int busy_low;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            start = 1'b1;
            value = vec_val[i];
            @(negedge clock);
            start = 1'b0;
            value = 16'h5A5A;
            lat = 1;
            busy_low = 0;
            while (!done && lat < 40) begin
                if (!busy) busy_low++;
                @(negedge clock);
                lat++;
            end
            checks++;
            if (lat != 18) begin
                failures++;
                $display("FAIL %s_latency: got %0d expected 18", vec_nam[i], lat);
            end
            checks++;
            if (digits !== vec_exp[i]) begin
                failures++;
                $display("FAIL %s_digits: got %h expected %h", vec_nam[i], digits, vec_exp[i]);
            end
            checks++;
            if (busy !== 1'b0 || busy_low != 0) begin
                failures++;
                $display("FAIL %s_busy: got busy=%b low_cycles=%0d expected 0/0",
                         vec_nam[i], busy, busy_low);
            end
            @(negedge clock);
            checks++;
            if (done !== 1'b0) begin
                failures++;
                $display("FAIL %s_pulse: got done=%b expected 0", vec_nam[i], done);
            end
            repeat (3) @(negedge clock);
            checks++;
            if (digits !== vec_exp[i]) begin
                failures++;
                $display("FAIL %s_hold: got %h expected %h", vec_nam[i], digits, vec_exp[i]);
            end
        end
    endtask

    task automatic test_busy_ignore();
        int lat;
        int extra;
        @(negedge clock);
        start = 1'b1;
        value = 16'd1234;
        @(negedge clock);
        lat = 1;
        while (!done && lat < 40) begin
            start = (lat == 3 || lat == 10);
            value = 16'd7;
            @(negedge clock);
            lat++;
        end
        start = 1'b0;
        checks++;
        if (lat != 18) begin
            failures++;
            $display("FAIL ignore_latency: got %0d expected 18", lat);
        end
        checks++;
        if (digits !== E_1234) begin
            failures++;
            $display("FAIL ignore_digits: got %h expected %h", digits, E_1234);
        end
        extra = 0;
        repeat (25) begin
            @(negedge clock);
            if (done || busy) extra++;
        end
        checks++;
        if (extra != 0) begin
            failures++;
            $display("FAIL ignore_noqueue: got %0d active cycles expected 0", extra);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        int gap;
        @(negedge clock);
        start = 1'b1;
        value = 16'd7;
        @(negedge clock);
        lat = 1;
        while (!done && lat < 40) begin
            value = 16'h1111;
            @(negedge clock);
            lat++;
        end
        checks++;
        if (lat != 18 || digits !== E_7) begin
            failures++;
            $display("FAIL b2b_first: got lat=%0d digits=%h expected 18/%h", lat, digits, E_7);
        end
        value = 16'hFFFB;
        @(negedge clock);
        start = 1'b0;
        value = 16'h0000;
        gap = 1;
        while (!done && gap < 40) begin
            @(negedge clock);
            gap++;
        end
        checks++;
        if (gap != 18) begin
            failures++;
            $display("FAIL b2b_gap: got %0d expected 18", gap);
        end
        checks++;
        if (digits !== E_M5) begin
            failures++;
            $display("FAIL b2b_digits: got %h expected %h", digits, E_M5);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        int extra;
        @(negedge clock);
        start = 1'b1;
        value = 16'd1234;
        @(negedge clock);
        start = 1'b0;
        lat = 1;
        while (lat < 7) begin
            @(negedge clock);
            lat++;
        end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checks++;
        if (digits !== E_RST || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL midreset_state: got digits=%h busy=%b done=%b expected %h/0/0",
                     digits, busy, done, E_RST);
        end
        extra = 0;
        repeat (25) begin
            @(negedge clock);
            if (done || busy) extra++;
        end
        checks++;
        if (extra != 0) begin
            failures++;
            $display("FAIL midreset_nodone: got %0d active cycles expected 0", extra);
        end
        // Reset and start together: reset must win.
        start = 1'b1;
        reset = 1'b1;
        value = 16'd1234;
        @(negedge clock);
        start = 1'b0;
        reset = 1'b0;
        extra = 0;
        repeat (22) begin
            if (done || busy) extra++;
            @(negedge clock);
        end
        checks++;
        if (extra != 0 || digits !== E_RST) begin
            failures++;
            $display("FAIL reset_start: got %0d active cycles digits=%h expected 0/%h",
                     extra, digits, E_RST);
        end
        start = 1'b1;
        value = 16'hFFFB;
        @(negedge clock);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 40) begin
            @(negedge clock);
            lat++;
        end
        checks++;
        if (lat != 18 || digits !== E_M5) begin
            failures++;
            $display("FAIL after_reset_m5: got lat=%0d digits=%h expected 18/%h", lat, digits, E_M5);
        end
    endtask

    initial begin
        vec_exp[0] = E_1234;
        vec_exp[1] = E_0;
        vec_exp[2] = E_M5;
        vec_exp[3] = E_MIN;
        vec_exp[4] = E_MAX;
        test_reset();
        test_values();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
